unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipelined core's instruction-fetch port and its data port.
- Turns per-port request levels into serialized memory accesses with a fixed read latency, and returns a one-cycle ready pulse to each requester.
- Sits between the processor core and the memory macro.
- A low ready holds the core in its stall path.
- Data accesses have priority. A streak counter bounds fetch starvation.

---
 rtl/unified_mem_arbiter_if.sv | 50 +++++
 rtl/unified_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
//   Bundles the fetch port, the data port and the memory-macro bus of the
//   unified memory arbiter.
//
//   Modports:
//     master : arbiter view. It takes the requests and mem_rdata, and drives
//              the ready pulses, the read data and the memory strobe/bus.
//     slave  : environment view (core ports plus memory macro).
//
//   Signals:
//     i_req, i_addr[31:0]                  fetch request, held until i_ready
//     i_rdata[31:0], i_ready               fetch data and completion pulse
//     d_req, d_we[3:0], d_addr, d_wdata    data request, held until d_ready
//     d_rdata[31:0], d_ready               load data and completion pulse
//     mem_en, mem_we[3:0], mem_addr,
//     mem_wdata                            one-cycle access to the memory
//     mem_rdata[31:0]                      memory read data (fixed latency)
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;

    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   data port of the core. Requests are sampled only in IDLE, data has
//   priority, and a streak counter forces a fetch grant after MAX_D_STREAK
//   consecutive data grants taken while a fetch was waiting. Each access
//   produces one registered ready pulse to its owner.
//
//   Parameters:
//     RD_LAT       cycles from the mem_en cycle to valid mem_rdata (>= 1)
//     MAX_D_STREAK data grants allowed in a row while i_req pends (>= 1)
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous reset, active low
//     bus    fetch/data/memory signals (unified_mem_arbiter_if.master)
//     busy   high whenever the FSM is outside IDLE
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int RD_LAT       = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    unified_mem_arbiter_if.master         bus,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [LW-1:0] LAT_INIT   = LW'(RD_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_t        state, state_d;
    owner_t        owner, owner_d;
    logic [LW-1:0] lat_cnt, lat_cnt_d;
    logic [SW-1:0] streak, streak_d;

    logic          mem_en_d;
    logic [3:0]    mem_we_d;
    logic [31:0]   mem_addr_d;
    logic [31:0]   mem_wdata_d;
    logic          i_ready_d, d_ready_d;
    logic          grant_d, grant_i;
    logic          enter_done;

    always_comb begin
        state_d     = state;
        owner_d     = owner;
        lat_cnt_d   = lat_cnt;
        streak_d    = streak;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = bus.mem_addr;
        mem_wdata_d = bus.mem_wdata;
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        enter_done  = 1'b0;

        case (state)
            IDLE: begin
                // Data wins unless a fetch has waited through a full streak.
                grant_d = bus.d_req & ~(bus.i_req & (streak == STREAK_MAX));
                grant_i = bus.i_req & ~grant_d;
                if (grant_d) begin
                    state_d     = ACCESS;
                    owner_d     = OWN_D;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    if (bus.i_req) begin
                        streak_d = (streak == STREAK_MAX) ? streak : streak + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_i) begin
                    state_d     = ACCESS;
                    owner_d     = OWN_I;
                    mem_en_d    = 1'b1;
                    mem_we_d    = '0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            ACCESS: begin
                if (bus.mem_we != '0 || RD_LAT == 1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_INIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt - LW'(1);
                if (lat_cnt == LW'(1)) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered so it is high exactly for the DONE cycle.
        i_ready_d = enter_done & (owner == OWN_I);
        d_ready_d = enter_done & (owner == OWN_D);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_I;
            lat_cnt       <= '0;
            streak        <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
        end else begin
            state         <= state_d;
            owner         <= owner_d;
            lat_cnt       <= lat_cnt_d;
            streak        <= streak_d;
            bus.mem_en    <= mem_en_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.i_ready   <= i_ready_d;
            bus.d_ready   <= d_ready_d;
        end
    end

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//   Drives two arbiter builds (RD_LAT=2/MAX_D_STREAK=4 and RD_LAT=1/
//   MAX_D_STREAK=2) with random fetch/data traffic. A transaction-level model
//   predicts, for every cycle, which port is granted, when mem_en and ready
//   appear, and what data each read returns. A small memory responder answers
//   the DUT's mem_en with data exactly RD_LAT cycles later.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int RL0 = 2;
    localparam int MS0 = 4;
    localparam int RL1 = 1;
    localparam int MS1 = 2;
    localparam int N_CYC = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        i_req     [2];
    logic [31:0] i_addr    [2];
    logic        d_req     [2];
    logic [3:0]  d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [31:0] mem_rdata [2];

    logic        i_ready_o   [2];
    logic        d_ready_o   [2];
    logic [31:0] i_rdata_o   [2];
    logic [31:0] d_rdata_o   [2];
    logic        mem_en_o    [2];
    logic [3:0]  mem_we_o    [2];
    logic [31:0] mem_addr_o  [2];
    logic [31:0] mem_wdata_o [2];
    logic        busy_o      [2];

    unified_mem_arbiter_if bus0 ();
    unified_mem_arbiter_if bus1 ();

    assign bus0.i_req     = i_req[0];
    assign bus0.i_addr    = i_addr[0];
    assign bus0.d_req     = d_req[0];
    assign bus0.d_we      = d_we[0];
    assign bus0.d_addr    = d_addr[0];
    assign bus0.d_wdata   = d_wdata[0];
    assign bus0.mem_rdata = mem_rdata[0];
    assign i_ready_o[0]   = bus0.i_ready;
    assign d_ready_o[0]   = bus0.d_ready;
    assign i_rdata_o[0]   = bus0.i_rdata;
    assign d_rdata_o[0]   = bus0.d_rdata;
    assign mem_en_o[0]    = bus0.mem_en;
    assign mem_we_o[0]    = bus0.mem_we;
    assign mem_addr_o[0]  = bus0.mem_addr;
    assign mem_wdata_o[0] = bus0.mem_wdata;

    assign bus1.i_req     = i_req[1];
    assign bus1.i_addr    = i_addr[1];
    assign bus1.d_req     = d_req[1];
    assign bus1.d_we      = d_we[1];
    assign bus1.d_addr    = d_addr[1];
    assign bus1.d_wdata   = d_wdata[1];
    assign bus1.mem_rdata = mem_rdata[1];
    assign i_ready_o[1]   = bus1.i_ready;
    assign d_ready_o[1]   = bus1.d_ready;
    assign i_rdata_o[1]   = bus1.i_rdata;
    assign d_rdata_o[1]   = bus1.d_rdata;
    assign mem_en_o[1]    = bus1.mem_en;
    assign mem_we_o[1]    = bus1.mem_we;
    assign mem_addr_o[1]  = bus1.mem_addr;
    assign mem_wdata_o[1] = bus1.mem_wdata;

    unified_mem_arbiter #(.RD_LAT(RL0), .MAX_D_STREAK(MS0)) u_dut0 (
        .clk   (clk),
        .reset (rst_n[0]),
        .bus   (bus0),
        .busy  (busy_o[0])
    );

    unified_mem_arbiter #(.RD_LAT(RL1), .MAX_D_STREAK(MS1)) u_dut1 (
        .clk   (clk),
        .reset (rst_n[1]),
        .bus   (bus1),
        .busy  (busy_o[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one outstanding transaction per build.
    int          rl [2];
    int          ms [2];
    bit          infl [2];
    int          t_g [2];
    int          t_rdy [2];
    int          nxt [2];
    int          streak [2];
    bit          m_isd [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [3:0]  m_we [2];
    logic [31:0] model_mem [2][16];

    // Memory responder state.
    logic [31:0] tb_mem [2][16];
    bit          sch_v [2][8];
    logic [31:0] sch_d [2][8];

    bit saw_i_rdy [2];
    bit saw_d_rdy [2];
    bit rst_done [2];
    bit pend_rel [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check_all_zero(input int k, input string when);
        check($sformatf("c%0d.%s.mem_en", k, when),    mem_en_o[k],    '0);
        check($sformatf("c%0d.%s.mem_we", k, when),    mem_we_o[k],    '0);
        check($sformatf("c%0d.%s.mem_addr", k, when),  mem_addr_o[k],  '0);
        check($sformatf("c%0d.%s.mem_wdata", k, when), mem_wdata_o[k], '0);
        check($sformatf("c%0d.%s.i_ready", k, when),   i_ready_o[k],   '0);
        check($sformatf("c%0d.%s.d_ready", k, when),   d_ready_o[k],   '0);
        check($sformatf("c%0d.%s.busy", k, when),      busy_o[k],      '0);
    endtask

    // Runs just after the rising edge: memory responder, then requesters.
    task automatic step_drive(input int k);
        logic [3:0] idx;
        if (pend_rel[k]) begin
            rst_n[k]    = 1'b1;
            pend_rel[k] = 1'b0;
        end
        if (mem_en_o[k]) begin
            idx = mem_addr_o[k][5:2];
            if (mem_we_o[k] != 4'b0)
                tb_mem[k][idx] = merge(tb_mem[k][idx], mem_wdata_o[k], mem_we_o[k]);
            else begin
                sch_v[k][(cyc + rl[k]) % 8] = 1'b1;
                sch_d[k][(cyc + rl[k]) % 8] = tb_mem[k][idx];
            end
        end
        mem_rdata[k] = sch_v[k][cyc % 8] ? sch_d[k][cyc % 8] : $urandom;
        sch_v[k][cyc % 8] = 1'b0;

        if (!i_req[k] || saw_i_rdy[k]) begin
            i_req[k]  = ($urandom_range(0, 3) != 0);
            i_addr[k] = $urandom;
        end
        if (!d_req[k] || saw_d_rdy[k]) begin
            d_req[k]   = ($urandom_range(0, 3) != 0);
            d_addr[k]  = $urandom;
            d_wdata[k] = $urandom;
            d_we[k]    = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
        end
        saw_i_rdy[k] = 1'b0;
        saw_d_rdy[k] = 1'b0;
    endtask

    // Runs on the falling edge: compare, then let the model take a grant.
    task automatic step_check(input int k);
        logic       e_en, e_ir, e_dr, e_busy, gd, gi;
        logic [3:0] e_we;
        logic [3:0] idx;
        string      p;
        p      = $sformatf("c%0d", k);
        e_en   = infl[k] && (cyc == t_g[k] + 1);
        e_we   = e_en ? m_we[k] : 4'b0;
        e_ir   = infl[k] && !m_isd[k] && (cyc == t_rdy[k]);
        e_dr   = infl[k] &&  m_isd[k] && (cyc == t_rdy[k]);
        e_busy = infl[k] && (cyc > t_g[k]) && (cyc <= t_rdy[k]);

        check({p, ".mem_en"},  mem_en_o[k],  e_en);
        check({p, ".mem_we"},  mem_we_o[k],  e_we);
        check({p, ".i_ready"}, i_ready_o[k], e_ir);
        check({p, ".d_ready"}, d_ready_o[k], e_dr);
        check({p, ".busy"},    busy_o[k],    e_busy);
        if (e_en) begin
            check({p, ".mem_addr"}, mem_addr_o[k], m_addr[k]);
            if (m_we[k] != 4'b0) check({p, ".mem_wdata"}, mem_wdata_o[k], m_wdata[k]);
        end
        if (e_ir) check({p, ".i_rdata"}, i_rdata_o[k], m_rdata[k]);
        if (e_dr && m_we[k] == 4'b0) check({p, ".d_rdata"}, d_rdata_o[k], m_rdata[k]);

        saw_i_rdy[k] = i_ready_o[k];
        saw_d_rdy[k] = d_ready_o[k];

        if (infl[k] && cyc == t_rdy[k]) begin
            infl[k] = 1'b0;
            nxt[k]  = t_rdy[k] + 1;
        end

        if (!infl[k] && cyc >= nxt[k] && rst_n[k]) begin
            gd = d_req[k] && !(i_req[k] && streak[k] == ms[k]);
            gi = i_req[k] && !gd;
            if (gd || gi) begin
                infl[k]    = 1'b1;
                t_g[k]     = cyc;
                m_isd[k]   = gd;
                m_addr[k]  = gd ? d_addr[k] : i_addr[k];
                m_we[k]    = gd ? d_we[k] : 4'b0;
                m_wdata[k] = d_wdata[k];
                idx        = m_addr[k][5:2];
                if (m_we[k] != 4'b0) begin
                    model_mem[k][idx] = merge(model_mem[k][idx], m_wdata[k], m_we[k]);
                    t_rdy[k] = cyc + 2;
                end else begin
                    m_rdata[k] = model_mem[k][idx];
                    t_rdy[k]   = cyc + 1 + rl[k];
                end
                if (gd && i_req[k]) streak[k] = (streak[k] < ms[k]) ? streak[k] + 1 : ms[k];
                else                streak[k] = 0;
            end
        end

        // Abandon an in-flight data read one cycle before its ready.
        if (!rst_done[k] && cyc > 20 && infl[k] && m_isd[k] && m_we[k] == 4'b0 &&
            cyc == t_g[k] + rl[k]) begin
            rst_n[k] = 1'b0;
            #1;
            check_all_zero(k, "midrst");
            infl[k]      = 1'b0;
            streak[k]    = 0;
            nxt[k]       = cyc + 1;
            i_req[k]     = 1'b0;
            d_req[k]     = 1'b0;
            saw_i_rdy[k] = 1'b0;
            saw_d_rdy[k] = 1'b0;
            rst_done[k]  = 1'b1;
            pend_rel[k]  = 1'b1;
        end
    endtask

    initial begin
        rl[0] = RL0; rl[1] = RL1;
        ms[0] = MS0; ms[1] = MS1;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 1'b0;
            i_req[k]     = 1'b0;
            d_req[k]     = 1'b0;
            i_addr[k]    = '0;
            d_addr[k]    = '0;
            d_we[k]      = '0;
            d_wdata[k]   = '0;
            mem_rdata[k] = '0;
            infl[k]      = 1'b0;
            nxt[k]       = 0;
            streak[k]    = 0;
            saw_i_rdy[k] = 1'b0;
            saw_d_rdy[k] = 1'b0;
            rst_done[k]  = 1'b0;
            pend_rel[k]  = 1'b0;
            for (int j = 0; j < 16; j++) begin
                model_mem[k][j] = $urandom;
                tb_mem[k][j]    = model_mem[k][j];
            end
            model_mem[k][0] = 32'h0050_0093;
            tb_mem[k][0]    = 32'h0050_0093;
            for (int j = 0; j < 8; j++) sch_v[k][j] = 1'b0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_all_zero(k, "reset");

        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk);
            #1;
            cyc = n;
            if (n == 0) begin
                for (int k = 0; k < 2; k++) begin
                    rst_n[k]  = 1'b1;
                    i_req[k]  = 1'b1;
                    i_addr[k] = 32'h0000_0100;
                end
            end else begin
                for (int k = 0; k < 2; k++) step_drive(k);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) step_check(k);
        end

        for (int k = 0; k < 2; k++)
            check($sformatf("c%0d.midread_reset_hit", k), rst_done[k], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
